// File: rtl/sync_to_e1of4_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_to_e1of4_tx_pkg
// Description : Shared types and helpers for the clocked-to-e1of4 transmit
//               bridge: FSM state encoding, digit/rail widths and the
//               2-bit to 1-of-4 rail encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_to_e1of4_tx_pkg;

    // Handshake FSM: neutral/ready, data on rails, waiting for enable return
    typedef enum logic [1:0] {
        S_NULL = 2'd0,
        S_DATA = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam int NDIG_DEFAULT = 1;
    localparam int DIGIT_W      = 2;   // binary bits per 1-of-4 digit
    localparam int RAIL_W       = 4;   // rails per 1-of-4 digit

    // Data width of a token carrying ndig digits
    function automatic int data_width(input int ndig);
        return DIGIT_W * ndig;
    endfunction

    // One-hot rail vector for a 2-bit digit value
    function automatic logic [RAIL_W-1:0] onehot4(input logic [DIGIT_W-1:0] v);
        return 4'b0001 << v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_to_e1of4_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_to_e1of4_tx_if
// Description : Bundles the synchronous valid/ready input and the e1of4
//               output channel of the transmit bridge.
//               in_data/in_valid/in_ready : clocked word input
//               Tx                        : 4*NDIG one-hot rails
//               Txe                       : asynchronous receiver enable
//               master : producer + receiver side (testbench / system)
//               slave  : the bridge itself
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_to_e1of4_tx_if #(
    parameter int NDIG = 1
) ();
    logic [2*NDIG-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [4*NDIG-1:0] Tx;
    logic              Txe;

    modport master (
        output in_data,
        output in_valid,
        output Txe,
        input  in_ready,
        input  Tx
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  Txe,
        output in_ready,
        output Tx
    );
endinterface
`default_nettype wire

// File: rtl/sync_to_e1of4_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Small synchronous FIFO with registered flags.
//               clk       : clock
//               rst_n     : synchronous active-low reset (flushes contents)
//               push      : write request, honoured only when wr_ready
//               push_data : write word
//               pop       : read request, honoured only when !empty
//               head      : oldest word (valid while !empty)
//               wr_ready  : space available (low during reset)
//               empty     : no words stored
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import sync_to_e1of4_tx_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             wr_ready,
    output logic             empty
);
    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             push_ok;
    logic             pop_ok;

    // Push is gated by the registered ready flag, so a full FIFO refuses a
    // push even when a pop happens in the same cycle.
    assign push_ok = push && wr_ready;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_next = count - 1'b1;
        end
    end

    // Flags are computed from the next occupancy so they are exact the
    // cycle after each transfer without any combinational path to ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            wr_ready <= (count_next != FULL_CNT);
            empty    <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sync_to_e1of4_tx.sv
`default_nettype none
// ============================================================================
// Module      : sync_to_e1of4_tx
// Description : Clocked-to-QDI transmit bridge. Buffers binary words from a
//               valid/ready interface and emits each as NDIG parallel 1-of-4
//               digits on an enable-qualified four-phase channel.
//               CLK      : system clock, rising edge
//               RESET    : synchronous active-low reset
//               bus      : in_data/in_valid/in_ready input, Tx rails, Txe
//               tx_count : tokens completed (wraps)
//               busy     : FIFO non-empty or handshake in progress
// Revision    : 1.0 - initial release
// ============================================================================
module sync_to_e1of4_tx
    import sync_to_e1of4_tx_pkg::*;
#(
    parameter int NDIG        = NDIG_DEFAULT,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    sync_to_e1of4_tx_if.slave    bus,
    output logic [CNT_W-1:0]     tx_count,
    output logic                 busy
);
    localparam int DATA_W  = data_width(NDIG);
    localparam int RAILS_W = RAIL_W * NDIG;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] txe_sync;
    logic                   txe_s;
    logic [RAILS_W-1:0]     tx_rails;
    logic [RAILS_W-1:0]     rails_next;
    logic [RAILS_W-1:0]     launch_rails;
    logic [CNT_W-1:0]       count_next;
    logic [DATA_W-1:0]      fifo_head;
    logic                   fifo_empty;
    logic                   fifo_ready;
    logic                   fifo_pop;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESET),
        .push      (bus.in_valid),
        .push_data (bus.in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .wr_ready  (fifo_ready),
        .empty     (fifo_empty)
    );

    assign bus.in_ready = fifo_ready;
    assign bus.Tx       = tx_rails;   // rails straight from flops
    assign txe_s        = txe_sync[SYNC_STAGES-1];
    assign busy         = !fifo_empty || (state != S_NULL);

    // Encode the FIFO head into rails; only latched on launch from S_NULL,
    // where the rails are all-zero, so a digit never passes through a
    // multi-hot value.
    always_comb begin
        launch_rails = '0;
        for (int d = 0; d < NDIG; d++) begin
            launch_rails[RAIL_W*d +: RAIL_W] = onehot4(fifo_head[DIGIT_W*d +: DIGIT_W]);
        end
    end

    always_comb begin
        state_next = state;
        rails_next = tx_rails;
        count_next = tx_count;
        fifo_pop   = 1'b0;
        case (state)
            S_NULL: begin
                rails_next = '0;
                if (!fifo_empty && txe_s) begin
                    fifo_pop   = 1'b1;
                    rails_next = launch_rails;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (!txe_s) begin
                    rails_next = '0;
                    count_next = tx_count + 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Returning to S_NULL rather than launching here keeps at
                // least one full neutral cycle between tokens.
                rails_next = '0;
                if (txe_s) begin
                    state_next = S_NULL;
                end
            end
            default: begin
                rails_next = '0;
                state_next = S_NULL;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            txe_sync <= '0;
            state    <= S_NULL;
            tx_rails <= '0;
            tx_count <= '0;
        end else begin
            txe_sync <= {txe_sync[SYNC_STAGES-2:0], bus.Txe};
            state    <= state_next;
            tx_rails <= rails_next;
            tx_count <= count_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_to_e1of4_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_to_e1of4_tx
// Description : Self-checking bench for sync_to_e1of4_tx (NDIG=2, CNT_W=4).
//               Accepted words push expected rail words into a queue; a
//               monitor pops on each rising token and checks rail rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_to_e1of4_tx;
    localparam int NDIG        = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [CNT_W-1:0] tx_count;
    logic             busy;

    sync_to_e1of4_tx_if #(.NDIG(NDIG)) bus ();

    sync_to_e1of4_tx #(
        .NDIG        (NDIG),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .bus      (bus),
        .tx_count (tx_count),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         rise_cnt = 0;
    int         pushes_done = 0;
    logic [7:0] exp_q[$];
    logic [7:0] prev_tx = '0;
    bit         rx_auto = 1'b0;
    int         dly = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent rail model: digit d value v sets bit 4*d+v
    function automatic logic [7:0] rails(input logic [3:0] d);
        logic [7:0] r;
        r = '0;
        r[d[1:0]]     = 1'b1;
        r[4 + d[3:2]] = 1'b1;
        return r;
    endfunction

    // Receiver model: drops Txe 3 cycles after rails rise, raises it 3
    // cycles after rails return to neutral.
    always @(negedge CLK) begin
        if (!rx_auto) begin
            dly = 0;
        end else if (bus.Txe && bus.Tx != 0) begin
            if (dly == 2) begin bus.Txe = 1'b0; dly = 0; end
            else dly++;
        end else if (!bus.Txe && bus.Tx == 0) begin
            if (dly == 2) begin bus.Txe = 1'b1; dly = 0; end
            else dly++;
        end else begin
            dly = 0;
        end
    end

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (RESET === 1'b1) begin
            n_tests++;
            if ($countones(bus.Tx[3:0]) > 1 || $countones(bus.Tx[7:4]) > 1) begin
                n_fail++;
                $display("FAIL multihot: got %0h expected one-hot digits", bus.Tx);
            end
            if (bus.Tx != 0 && prev_tx != 0 && bus.Tx != prev_tx) begin
                n_tests++; n_fail++;
                $display("FAIL rail_stable: got %0h expected %0h", bus.Tx, prev_tx);
            end
            if (bus.Tx != 0 && prev_tx == 0) begin
                rise_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL spurious_token: got %0h expected none", bus.Tx);
                end else begin
                    check("token_rails", 32'(bus.Tx), 32'(exp_q.pop_front()));
                end
            end
        end
        prev_tx = bus.Tx;
    end

    // Drive one word, hold until accepted, record the expected rails.
    task automatic push(input logic [3:0] d, input logic [7:0] exp_rails);
        bit rdy;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 400; t++) begin
            rdy = bus.in_ready;
            @(posedge CLK);
            if (rdy) begin
                exp_q.push_back(exp_rails);
                pushes_done++;
                #1 bus.in_valid = 1'b0;
                @(negedge CLK);
                return;
            end
            @(negedge CLK);
        end
        bus.in_valid = 1'b0;
        check("push_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge CLK);
            if (!busy && exp_q.size() == 0) return;
        end
        check("idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int rises0;
        logic [3:0] d;

        // ---------------- Reset ----------------
        RESET        = 1'b0;
        bus.Txe      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hF;
        repeat (5) @(negedge CLK);
        check("rst_tx", 32'(bus.Tx), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_tx_count", 32'(tx_count), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'h1);
        bus.in_valid = 1'b0;
        @(negedge CLK);
        check("rel_busy", 32'(busy), 32'h0);

        // ---------------- Single token ----------------
        rx_auto = 1'b1;
        push(4'h2, 8'h14);
        k = 0;
        for (int t = 0; t < 50 && bus.Tx == 0; t++) @(negedge CLK);
        check("single_rise", 32'(bus.Tx), 32'h14);
        for (int t = 1; t <= 30; t++) begin
            @(posedge CLK); #1;
            if (bus.Tx == 0) begin k = t; break; end
        end
        check("single_hold_cycles", 32'(k), 32'd5);
        check("single_count", 32'(tx_count), 32'd1);
        wait_idle(200);

        // ---------------- Ordered stream + backpressure ----------------
        rx_auto = 1'b0;
        bus.Txe = 1'b0;
        repeat (4) @(negedge CLK);
        pushes_done = 0;
        fork
            begin
                push(4'h0, 8'h11);
                push(4'h5, 8'h22);
                push(4'hA, 8'h44);
                push(4'hF, 8'h88);
                push(4'h3, 8'h18);
            end
            begin
                for (int t = 0; t < 100 && pushes_done < 4; t++) @(negedge CLK);
                repeat (3) @(negedge CLK);
                check("bp_in_ready", 32'(bus.in_ready), 32'h0);
                check("bp_tx", 32'(bus.Tx), 32'h0);
                check("bp_busy", 32'(busy), 32'h1);
                check("bp_pushes", 32'(pushes_done), 32'd4);
                bus.Txe = 1'b1;
                k = 0;
                for (int t = 1; t <= 20; t++) begin
                    @(posedge CLK); #1;
                    if (bus.Tx != 0) begin k = t; break; end
                end
                check("bp_latency", 32'(k), 32'(SYNC_STAGES + 1));
                rx_auto = 1'b1;
            end
        join
        wait_idle(500);
        check("stream_count", 32'(tx_count), 32'd6);

        // ---------------- Mid-handshake reset ----------------
        push(4'h9, 8'h42);
        push(4'h6, 8'h24);
        for (int t = 0; t < 50 && bus.Tx == 0; t++) @(negedge CLK);
        check("mid_in_data", 32'(bus.Tx != 0), 32'd1);
        RESET   = 1'b0;
        rx_auto = 1'b0;
        bus.Txe = 1'b1;
        @(posedge CLK); #1;
        check("mid_rst_tx", 32'(bus.Tx), 32'h0);
        check("mid_rst_count", 32'(tx_count), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        exp_q.delete();
        @(negedge CLK);
        RESET   = 1'b1;
        rx_auto = 1'b1;
        rises0  = rise_cnt;
        repeat (30) @(negedge CLK);
        check("mid_no_spurious", 32'(rise_cnt - rises0), 32'd0);
        check("mid_idle_busy", 32'(busy), 32'h0);

        // ---------------- Counter wrap ----------------
        rises0 = rise_cnt;
        for (int i = 0; i < 17; i++) begin
            d = 4'($urandom_range(0, 15));
            push(d, rails(d));
        end
        wait_idle(2000);
        check("wrap_tokens", 32'(rise_cnt - rises0), 32'd17);
        check("wrap_count", 32'(tx_count), 32'd1);
        check("final_tx", 32'(bus.Tx), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_to_e1of4_tx.md
Name: sync_to_e1of4_tx

Overview:
- Clocked-to-QDI transmit bridge: accepts binary words on a synchronous valid/ready interface, buffers them in a small FIFO, and emits each word as NDIG parallel 1-of-4 digits on an enable-qualified (e1of4) four-phase channel.
- Sits directly upstream of the e1of4 register's Tx data channel, in place of a behavioural bin-to-QDI driver.
- The returned enable is asynchronous to CLK and is synchronized internally.

Parameters:
- NDIG, 1: number of 1-of-4 digits per token; data width is 2*NDIG bits.
- FIFO_DEPTH, 4: input FIFO entries; must be a power of two and at least 2.
- SYNC_STAGES, 2: flop stages on the Txe synchronizer; at least 2.
- CNT_W, 16: width of the sent-token counter.

Ports:
- CLK  input  1  system clock; all state is rising-edge.
- RESET  input  1  synchronous active-low reset (0 = in reset), sampled on the CLK rising edge.
- in_data  input  2*NDIG  binary word; bits [2d+1:2d] form digit d.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept; a transfer happens when in_valid && in_ready at a CLK edge.
- Tx  output  4*NDIG  1-of-4 rails; Tx[4d+v] is high when digit d carries value v.
- Txe  input  1  asynchronous enable from the receiver: 1 = ready for data, 0 = data acknowledged.
- tx_count  output  CNT_W  number of tokens completed (neutral phase entered since reset).
- busy  output  1  FIFO non-empty or a handshake is in progress.

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - Tx=0, in_ready=0, tx_count=0, busy=0.
  - FIFO is flushed; synchronizer flops are cleared to 0; FSM goes to S_NULL.
  - Reset applied mid-handshake drops the rails to neutral on that edge. The receiver is required to be reset concurrently.
- After reset release: in_ready = !fifo_full, registered. Push and pop in the same cycle are allowed. A push while full is blocked, and there is no bypass path.
- txe_s is the Txe level delayed by SYNC_STAGES flops.
- FSM state S_NULL:
  - Tx=0.
  - If the FIFO is non-empty and txe_s=1: pop the head, register the rails (Tx[4d+word[2d+1:2d]]=1 for every d, all other rails 0), and go to S_DATA.
  - Otherwise stay in S_NULL.
- FSM state S_DATA:
  - Rails are held stable.
  - If txe_s=0: Tx goes to 0 on the same edge, tx_count increments (wraps modulo 2^CNT_W), and the FSM goes to S_WAIT.
- FSM state S_WAIT:
  - Tx=0.
  - If txe_s=1 (receiver returned to ready): go to S_NULL. No new token launches in this cycle, which guarantees at least one full neutral cycle.
- Rail rules:
  - Rails come straight from flops, never from combinational logic.
  - Each digit is exactly one-hot in S_DATA and all-zero otherwise. A digit is never multi-hot, even transiently.
- Latency:
  - A word accepted at edge N reaches the head of an empty FIFO at edge N.
  - Its rails rise at edge N+1, provided txe_s is already 1.
- Throughput: each token takes at least 2*SYNC_STAGES+3 cycles, plus the receiver delay.
- Txe glitch or pulse shorter than one cycle may be missed. This is acceptable, because QDI enables are monotonic per phase.
- busy = fifo_nonempty || state != S_NULL.
- Assertions for verification:
  - Tx is never non-zero outside S_DATA.
  - No digit is ever multi-hot.
  - Tx stays stable throughout S_DATA.

Decomposition:
- Shared package holds:
  - The FSM state enumeration {S_NULL, S_DATA, S_WAIT}.
  - A function onehot4(2-bit) returning a 4-bit rail vector.
  - A localparam for data width, 2*NDIG.
- Sub-module sync_fifo (parametric width/depth, full/empty flags, synchronous active-low reset) is natural.
- The synchronizer stays inline as a shift register.

Test Plan:
- Reset: hold RESET=0 for 5 cycles with in_valid=1 and Txe=1 -> Tx=0, in_ready=0, tx_count=0. After release, in_ready=1 on the next edge.
- Single token, NDIG=1, in_data=2'b10, with a responsive receiver model (Txe falls 3 cycles after a rail rises, rises 3 cycles after neutral):
  - Tx=4'b0100 is held until txe_s=0, then Tx=0 and tx_count=1.
- Ordered stream, NDIG=2: push 0x0,0x5,0xA,0xF,0x3 back-to-back -> rail words 8'h11, 8'h22, 8'h44, 8'h88, 8'h18 in order.
  - in_ready deasserts after 4 pushes while Txe is held 0, then the 5th push completes once a slot frees.
- Backpressure: hold Txe=0 indefinitely with 4 words queued -> Tx stays 0 and busy=1. Release Txe=1 -> the first token launches SYNC_STAGES+1 cycles later.
- Mid-handshake reset: assert RESET=0 while in S_DATA -> Tx=0 on that edge, FIFO empty, tx_count=0, and no spurious token after release.
- Counter wrap, CNT_W=4: complete 17 tokens of random data -> tx_count=1, and every rail check holds throughout.
